// File: rtl/ram_arb_pkg.sv
// Shared types and defaults for the two-port RAM arbiter.
package ram_arb_pkg;

    localparam int NUM_PORTS      = 2;
    localparam int ADDR_WIDTH_DEF = 8;
    localparam int DATA_WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_e;

endpackage

// File: rtl/ram_arbiter_rr_arbiter2.sv
// Two-way round-robin winner select with a registered last-grant pointer.
module rr_arbiter2 (
    input  logic clk,
    input  logic rst_n,
    input  logic req0,
    input  logic req1,
    input  logic gnt_en,
    output logic win
);

    logic last_gnt_q;
    logic last_gnt_d;

    // Contention goes to the port that did not win last; pointer resets to 1 so port 0 wins first.
    always_comb begin
        if (req0 && req1) begin
            win = ~last_gnt_q;
        end else if (req1) begin
            win = 1'b1;
        end else begin
            win = 1'b0;
        end
    end

    always_comb begin
        last_gnt_d = last_gnt_q;
        if (gnt_en) begin
            last_gnt_d = win;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_gnt_q <= 1'b1;
        end else begin
            last_gnt_q <= last_gnt_d;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Serialises two requesters onto the single-port byte-strobed RAM.
//   state  | meaning
//   IDLE   | waiting for a request; grants and latches the winner's command
//   ACCESS | ram_en high for one cycle with the latched command
//   RESP   | RAM read data valid; pulse owner's done, load its rdata on reads
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0,
    input  logic                  we0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [STRB_WIDTH-1:0] strb0,
    input  logic                  req1,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata1,
    input  logic [STRB_WIDTH-1:0] strb1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  done0,
    output logic                  done1,
    output logic [DATA_WIDTH-1:0] rdata0,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic                  ram_en,
    output logic                  ram_wr_rd,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic [STRB_WIDTH-1:0] ram_strb,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);

    arb_state_e state_q, state_d;
    logic owner_q, owner_d;
    logic gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic done0_q, done0_d, done1_q, done1_d;
    logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic ram_en_q, ram_en_d;
    logic ram_wr_rd_q, ram_wr_rd_d;
    logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_WIDTH-1:0] ram_wdata_q, ram_wdata_d;
    logic [STRB_WIDTH-1:0] ram_strb_q, ram_strb_d;

    logic any_req;
    logic grant;
    logic win;

    assign any_req = req0 | req1;
    assign grant   = (state_q == IDLE) && any_req;

    rr_arbiter2 u_rr (
        .clk    (clk),
        .rst_n  (rst_n),
        .req0   (req0),
        .req1   (req1),
        .gnt_en (grant),
        .win    (win)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            done0_q     <= 1'b0;
            done1_q     <= 1'b0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
            ram_en_q    <= 1'b0;
            ram_wr_rd_q <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            ram_strb_q  <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            gnt0_q      <= gnt0_d;
            gnt1_q      <= gnt1_d;
            done0_q     <= done0_d;
            done1_q     <= done1_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
            ram_en_q    <= ram_en_d;
            ram_wr_rd_q <= ram_wr_rd_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            ram_strb_q  <= ram_strb_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = ACCESS;
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The RAM command outputs double as the command register, so they hold between accesses.
    always_comb begin
        owner_d     = owner_q;
        gnt0_d      = 1'b0;
        gnt1_d      = 1'b0;
        done0_d     = 1'b0;
        done1_d     = 1'b0;
        rdata0_d    = rdata0_q;
        rdata1_d    = rdata1_q;
        ram_en_d    = 1'b0;
        ram_wr_rd_d = ram_wr_rd_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        ram_strb_d  = ram_strb_q;
        case (state_q)
            IDLE: begin
                if (grant) begin
                    owner_d  = win;
                    gnt0_d   = ~win;
                    gnt1_d   = win;
                    ram_en_d = 1'b1;
                    if (win) begin
                        ram_wr_rd_d = we1;
                        ram_addr_d  = addr1;
                        ram_wdata_d = wdata1;
                        ram_strb_d  = strb1;
                    end else begin
                        ram_wr_rd_d = we0;
                        ram_addr_d  = addr0;
                        ram_wdata_d = wdata0;
                        ram_strb_d  = strb0;
                    end
                end
            end
            RESP: begin
                if (owner_q) begin
                    done1_d = 1'b1;
                    if (!ram_wr_rd_q) rdata1_d = ram_rdata;
                end else begin
                    done0_d = 1'b1;
                    if (!ram_wr_rd_q) rdata0_d = ram_rdata;
                end
            end
            default: begin
            end
        endcase
    end

    assign gnt0      = gnt0_q;
    assign gnt1      = gnt1_q;
    assign done0     = done0_q;
    assign done1     = done1_q;
    assign rdata0    = rdata0_q;
    assign rdata1    = rdata1_q;
    assign ram_en    = ram_en_q;
    assign ram_wr_rd = ram_wr_rd_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign ram_strb  = ram_strb_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: RAM model, transaction-level reference model, monitor.
module tb_ram_arbiter;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic clk = 1'b0;
    logic rst_n;
    logic req0, we0, req1, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic [SW-1:0] strb0, strb1;
    logic gnt0, gnt1, done0, done1;
    logic [DW-1:0] rdata0, rdata1;
    logic ram_en, ram_wr_rd;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [SW-1:0] ram_strb;
    logic [DW-1:0] ram_rdata;

    always #5 clk = ~clk;

    ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .strb0(strb0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .strb1(strb1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .rdata0(rdata0), .rdata1(rdata1),
        .ram_en(ram_en), .ram_wr_rd(ram_wr_rd), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_strb(ram_strb), .ram_rdata(ram_rdata)
    );

    // RAM: registered read, zero when idle, writes ignored while in reset.
    bit [DW-1:0] ram_mem [256];
    always @(posedge clk) begin
        if (!rst_n) begin
            ram_rdata <= '0;
        end else if (ram_en) begin
            if (ram_wr_rd) begin
                for (int b = 0; b < SW; b++)
                    if (ram_strb[b]) ram_mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
                ram_rdata <= '0;
            end else begin
                ram_rdata <= ram_mem[ram_addr];
            end
        end else begin
            ram_rdata <= '0;
        end
    end

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [SW-1:0] strb;
    } cmd_t;
    typedef struct packed { logic port; cmd_t cmd; } gexp_t;
    typedef struct packed { logic port; logic rd; logic [DW-1:0] data; } dexp_t;

    gexp_t gnt_q[$];
    dexp_t done_q[$];
    bit [DW-1:0] ref_mem [256];
    int model_last;
    int checks = 0;
    int failures = 0;

    function automatic cmd_t mk(input logic we, input logic [AW-1:0] a,
                                input logic [DW-1:0] d, input logic [SW-1:0] s);
        cmd_t c;
        c.we = we; c.addr = a; c.wdata = d; c.strb = s;
        return c;
    endfunction

    // Reference model: transactions apply in grant order to a flat memory image.
    task automatic model_txn(input int p, input cmd_t c, input bit completes);
        gexp_t g;
        dexp_t d;
        g.port = (p == 1); g.cmd = c;
        gnt_q.push_back(g);
        model_last = p;
        if (completes) begin
            d.port = (p == 1); d.rd = !c.we; d.data = '0;
            if (c.we) begin
                for (int b = 0; b < SW; b++)
                    if (c.strb[b]) ref_mem[c.addr][8*b +: 8] = c.wdata[8*b +: 8];
            end else begin
                d.data = ref_mem[c.addr];
            end
            done_q.push_back(d);
        end
    endtask

    task automatic drive(input cmd_t c0, input cmd_t c1);
        we0 = c0.we; addr0 = c0.addr; wdata0 = c0.wdata; strb0 = c0.strb;
        we1 = c1.we; addr1 = c1.addr; wdata1 = c1.wdata; strb1 = c1.strb;
    endtask

    task automatic do_round(input bit r0, input bit r1, input cmd_t c0, input cmd_t c1);
        int n;
        if (r0 && r1) begin
            if (model_last == 0) begin model_txn(1, c1, 1); model_txn(0, c0, 1); end
            else begin model_txn(0, c0, 1); model_txn(1, c1, 1); end
        end else if (r0) begin
            model_txn(0, c0, 1);
        end else if (r1) begin
            model_txn(1, c1, 1);
        end
        drive(c0, c1);
        req0 = r0; req1 = r1;
        n = 0;
        while ((req0 || req1) && n < 40) begin
            @(negedge clk);
            n++;
            if (gnt0) req0 = 1'b0;
            if (gnt1) req1 = 1'b0;
        end
        checks++;
        if (req0 || req1) begin
            failures++;
            $display("FAIL round_timeout: req still pending req0=%0b req1=%0b after %0d cycles", req0, req1, n);
            req0 = 1'b0; req1 = 1'b0;
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic hold_both(input int k, input cmd_t c0, input cmd_t c1);
        int seen, n, p;
        for (int i = 0; i < 2 * k; i++) begin
            p = (model_last == 0) ? 1 : 0;
            model_txn(p, (p == 1) ? c1 : c0, 1);
        end
        drive(c0, c1);
        req0 = 1'b1; req1 = 1'b1;
        seen = 0; n = 0;
        while (seen < 2 * k && n < 10 * k) begin
            @(negedge clk);
            n++;
            if (gnt0 || gnt1) seen++;
        end
        req0 = 1'b0; req1 = 1'b0;
        checks++;
        if (seen != 2 * k) begin
            failures++;
            $display("FAIL hold_timeout: grants seen=%0d required=%0d", seen, 2 * k);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_last = 1;
    endtask

    // Grant a write then pull reset during its ACCESS cycle: no completion, no RAM change.
    task automatic abort_write(input cmd_t c0);
        int n;
        model_txn(0, c0, 0);
        drive(c0, mk(0, '0, '0, '0));
        req0 = 1'b1;
        n = 0;
        while (req0 && n < 10) begin
            @(negedge clk);
            n++;
            if (gnt0) req0 = 1'b0;
        end
        checks++;
        if (req0) begin
            failures++;
            $display("FAIL abort_timeout: gnt0 not seen");
            req0 = 1'b0;
        end
        apply_reset();
    endtask

    // Monitor: samples 1 time unit after each rising edge.
    logic [DW-1:0] exp_rd [2];
    bit   pend [2];
    int   gnt_cyc [2];
    int   cyc = 0;
    bit   prev_en = 1'b0;
    logic rst_at_edge;

    always begin
        @(posedge clk);
        rst_at_edge = rst_n;
        #1;
        cyc++;
        if (!rst_at_edge) begin
            checks++;
            if (gnt0 !== 1'b0 || gnt1 !== 1'b0 || done0 !== 1'b0 || done1 !== 1'b0 ||
                ram_en !== 1'b0 || ram_wr_rd !== 1'b0 || ram_addr !== '0 ||
                ram_wdata !== '0 || ram_strb !== '0 || rdata0 !== '0 || rdata1 !== '0) begin
                failures++;
                $display("FAIL reset_values: gnt=%b%b done=%b%b en=%b wr=%b addr=%h wdata=%h strb=%h rd0=%h rd1=%h, all required 0",
                         gnt1, gnt0, done1, done0, ram_en, ram_wr_rd, ram_addr, ram_wdata, ram_strb, rdata0, rdata1);
            end
            exp_rd[0] = '0; exp_rd[1] = '0;
            pend[0] = 1'b0; pend[1] = 1'b0;
            prev_en = 1'b0;
        end else begin
            if (ram_en === 1'b1) begin
                checks++;
                if (prev_en) begin
                    failures++;
                    $display("FAIL ram_en_width: ram_en high in consecutive cycles at cycle %0d", cyc);
                end
            end
            prev_en = (ram_en === 1'b1);
            for (int p = 0; p < 2; p++) begin
                logic g, d;
                gexp_t ge;
                dexp_t de;
                g = (p == 0) ? gnt0 : gnt1;
                d = (p == 0) ? done0 : done1;
                if (g === 1'b1) begin
                    checks++;
                    if (gnt_q.size() == 0) begin
                        failures++;
                        $display("FAIL gnt_unexpected: gnt%0d with nothing expected", p);
                    end else begin
                        ge = gnt_q.pop_front();
                        if (ge.port != (p == 1) || ram_en !== 1'b1 || ram_wr_rd !== ge.cmd.we ||
                            ram_addr !== ge.cmd.addr ||
                            (ge.cmd.we && (ram_wdata !== ge.cmd.wdata || ram_strb !== ge.cmd.strb))) begin
                            failures++;
                            $display("FAIL gnt_cmd: got port=%0d en=%b wr=%b addr=%h wdata=%h strb=%h, required port=%0d en=1 wr=%b addr=%h wdata=%h strb=%h",
                                     p, ram_en, ram_wr_rd, ram_addr, ram_wdata, ram_strb,
                                     ge.port, ge.cmd.we, ge.cmd.addr, ge.cmd.wdata, ge.cmd.strb);
                        end
                    end
                    gnt_cyc[p] = cyc;
                    pend[p] = 1'b1;
                end
                if (d === 1'b1) begin
                    checks++;
                    if (done_q.size() == 0) begin
                        failures++;
                        $display("FAIL done_unexpected: done%0d with nothing expected", p);
                    end else begin
                        de = done_q.pop_front();
                        if (de.port != (p == 1) || !pend[p] || cyc - gnt_cyc[p] != 2) begin
                            failures++;
                            $display("FAIL done_order: got done%0d latency=%0d pending=%0b, required done%0d latency=2",
                                     p, cyc - gnt_cyc[p], pend[p], de.port);
                        end
                        if (de.rd) exp_rd[de.port] = de.data;
                    end
                    pend[p] = 1'b0;
                    checks++;
                    if (rdata0 !== exp_rd[0] || rdata1 !== exp_rd[1]) begin
                        failures++;
                        $display("FAIL rdata: got rdata0=%h rdata1=%h, required rdata0=%h rdata1=%h",
                                 rdata0, rdata1, exp_rd[0], exp_rd[1]);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        cmd_t nc;
        int sel;
        nc = mk(1'b0, '0, '0, '0);
        rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0;
        model_last = 1;
        drive(nc, nc);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        do_round(1, 0, mk(1, 8'h10, 32'hAABBCCDD, 4'hF), nc);
        do_round(1, 0, mk(0, 8'h10, '0, '0), nc);

        do_round(1, 0, mk(1, 8'h20, 32'h11223344, 4'hF), nc);
        do_round(1, 0, mk(1, 8'h20, 32'hFFFFFFFF, 4'h5), nc);
        do_round(1, 0, mk(0, 8'h20, '0, '0), nc);

        apply_reset();
        hold_both(4, mk(0, 8'h10, '0, '0), mk(0, 8'h20, '0, '0));

        do_round(1, 0, mk(1, 8'h34, 32'h12345678, 4'hF), nc);
        do_round(1, 0, mk(0, 8'h34, '0, '0), nc);
        do_round(0, 1, nc, mk(0, 8'h30, '0, '0));

        do_round(1, 0, mk(1, 8'h40, 32'h01020304, 4'hF), nc);
        abort_write(mk(1, 8'h40, 32'hDEADBEEF, 4'hF));
        do_round(1, 0, mk(0, 8'h40, '0, '0), nc);

        do_round(0, 1, nc, mk(1, 8'h50, 32'hCAFEF00D, 4'hF));
        do_round(0, 1, nc, mk(1, 8'h50, 32'h00000000, 4'h0));
        do_round(1, 0, mk(0, 8'h50, '0, '0), nc);

        for (int i = 0; i < 40; i++) begin
            cmd_t c0, c1;
            sel = $urandom_range(1, 3);
            c0 = mk(1'($urandom_range(0, 1)), 8'h60 + 8'($urandom_range(0, 7)), $urandom, 4'($urandom_range(0, 15)));
            c1 = mk(1'($urandom_range(0, 1)), 8'h60 + 8'($urandom_range(0, 7)), $urandom, 4'($urandom_range(0, 15)));
            do_round((sel & 1) != 0, (sel & 2) != 0, c0, c1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        checks++;
        if (gnt_q.size() != 0 || done_q.size() != 0) begin
            failures++;
            $display("FAIL queue_drain: gnt left=%0d done left=%0d, required 0 and 0", gnt_q.size(), done_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
